// File: rtl/snax_hwpe_to_reqrsp_wide.sv
// snax_hwpe_to_reqrsp_wide: HWPE TCDM master to reqrsp TCDM bridge with lane steering, in-order tag queue and credit limit
// Ports: clk_i/rst_i (sync active-high); hwpe_* HWPE master side (req/gnt, addr, wen=1 read, be, data, r_data/r_valid);
// tcdm_q_* reqrsp request channel; tcdm_p_* reqrsp response channel (ready tied 1); busy_o activity; err_o sticky stray response.
module snax_hwpe_to_reqrsp_wide #(
  parameter int AddrWidth      = 48,
  parameter int DataWidth      = 64,
  parameter int HwpeDataWidth  = 32,
  parameter int AddrShift      = 0,
  parameter int ReqFifoDepth   = 8,
  parameter int MaxOutstanding = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       hwpe_req_i,
  output logic                       hwpe_gnt_o,
  input  logic [31:0]                hwpe_add_i,
  input  logic                       hwpe_wen_i,
  input  logic [HwpeDataWidth/8-1:0] hwpe_be_i,
  input  logic [HwpeDataWidth-1:0]   hwpe_data_i,
  output logic [HwpeDataWidth-1:0]   hwpe_r_data_o,
  output logic                       hwpe_r_valid_o,
  output logic                       tcdm_q_valid_o,
  input  logic                       tcdm_q_ready_i,
  output logic [AddrWidth-1:0]       tcdm_q_addr_o,
  output logic                       tcdm_q_write_o,
  output logic [DataWidth-1:0]       tcdm_q_data_o,
  output logic [DataWidth/8-1:0]     tcdm_q_strb_o,
  input  logic                       tcdm_p_valid_i,
  input  logic [DataWidth-1:0]       tcdm_p_data_i,
  output logic                       tcdm_p_ready_o,
  output logic                       busy_o,
  output logic                       err_o
);
  localparam int Lanes = DataWidth / HwpeDataWidth;
  localparam int LaneW = Lanes > 1 ? $clog2(Lanes) : 1;
  localparam int BeW   = HwpeDataWidth / 8;
  localparam int OffW  = $clog2(BeW);
  localparam int StrbW = DataWidth / 8;
  localparam int EntW  = AddrWidth + 1 + DataWidth + StrbW;
  localparam int RPtrW = $clog2(ReqFifoDepth);
  localparam int RCntW = $clog2(ReqFifoDepth + 1);
  localparam int TPtrW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam int CntW  = $clog2(MaxOutstanding + 1);
  logic [EntW-1:0]  rmem_q [ReqFifoDepth];
  logic [LaneW:0]   tmem_q [MaxOutstanding];
  logic [RPtrW-1:0] rwp_q, rwp_d, rrp_q, rrp_d;
  logic [RCntW-1:0] rcnt_q, rcnt_d;
  logic [TPtrW-1:0] twp_q, twp_d, trp_q, trp_d;
  logic [CntW-1:0]  ocnt_q, ocnt_d;
  logic             err_q, err_d, rst_q;
  logic [31:0]      sh;
  logic [LaneW-1:0] lane;
  logic [StrbW-1:0] strb;
  logic [LaneW:0]   tag;
  logic             accept, q_pop, p_ok, p_fire;
  assign sh     = hwpe_add_i << AddrShift;
  assign lane   = Lanes > 1 ? sh[OffW +: LaneW] : '0;
  assign strb   = hwpe_wen_i ? '1 : StrbW'(hwpe_be_i) << (lane * BeW);
  assign hwpe_gnt_o = !rst_i & hwpe_req_i & (rcnt_q != RCntW'(ReqFifoDepth)) & (ocnt_q < CntW'(MaxOutstanding));
  assign accept = hwpe_req_i & hwpe_gnt_o;
  assign tcdm_q_valid_o = !rst_i & (rcnt_q != '0);
  assign q_pop  = tcdm_q_valid_o & tcdm_q_ready_i;
  assign {tcdm_q_addr_o, tcdm_q_write_o, tcdm_q_data_o, tcdm_q_strb_o} = rmem_q[rrp_q];
  // Responses are ignored during reset and in the first cycle after it, so stale in-flight beats are dropped cleanly
  assign p_ok   = tcdm_p_valid_i & !rst_i & !rst_q;
  assign p_fire = p_ok & (ocnt_q != '0);
  assign tag    = tmem_q[trp_q];
  assign hwpe_r_valid_o = p_fire & !tag[LaneW];
  assign hwpe_r_data_o  = hwpe_r_valid_o ? tcdm_p_data_i[tag[LaneW-1:0] * HwpeDataWidth +: HwpeDataWidth] : '0;
  assign tcdm_p_ready_o = 1'b1;
  assign busy_o = !rst_i & ((rcnt_q != '0) | (ocnt_q != '0));
  assign err_o  = err_q;
  always_comb begin
    rwp_d  = rwp_q + RPtrW'(accept);
    rrp_d  = rrp_q + RPtrW'(q_pop);
    rcnt_d = rcnt_q + RCntW'(accept) - RCntW'(q_pop);
    twp_d  = accept ? (twp_q == TPtrW'(MaxOutstanding - 1) ? '0 : twp_q + 1'b1) : twp_q;
    trp_d  = p_fire ? (trp_q == TPtrW'(MaxOutstanding - 1) ? '0 : trp_q + 1'b1) : trp_q;
    ocnt_d = ocnt_q + CntW'(accept) - CntW'(p_fire);
    err_d  = err_q | (p_ok & (ocnt_q == '0));
  end
  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
    if (rst_i) begin
      rwp_q  <= '0;
      rrp_q  <= '0;
      rcnt_q <= '0;
      twp_q  <= '0;
      trp_q  <= '0;
      ocnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      rwp_q  <= rwp_d;
      rrp_q  <= rrp_d;
      rcnt_q <= rcnt_d;
      twp_q  <= twp_d;
      trp_q  <= trp_d;
      ocnt_q <= ocnt_d;
      err_q  <= err_d;
    end
    if (accept) rmem_q[rwp_q] <= {AddrWidth'(sh), !hwpe_wen_i, {Lanes{hwpe_data_i}}, strb};
    if (accept) tmem_q[twp_q] <= {!hwpe_wen_i, lane};
  end
endmodule

// File: tb/tb_snax_hwpe_to_reqrsp_wide.sv
// tb_snax_hwpe_to_reqrsp_wide: vector table, random model comparison and directed corner sequences
module tb_snax_hwpe_to_reqrsp_wide;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic req = 0, wen = 1, gnt, rvalid, qv, qr = 1, qw, pv = 0, pr, busy, err;
  logic [31:0] add = 0, wdata = 0, rdata;
  logic [3:0] be = 0;
  logic [47:0] qaddr;
  logic [63:0] qd, pd = 0;
  logic [7:0] qs;
  logic w_req = 0, w_wen = 1, w_gnt, w_rvalid, w_qv, w_qr = 1, w_qw, w_pv = 0, w_pr, w_busy, w_err;
  logic [31:0] w_add = 0, w_wdata = 0, w_rdata;
  logic [3:0] w_be = 0;
  logic [47:0] w_qaddr;
  logic [127:0] w_qd, w_pd = 0;
  logic [15:0] w_qs;
  snax_hwpe_to_reqrsp_wide u_dut (
    .clk_i(clk), .rst_i(rst), .hwpe_req_i(req), .hwpe_gnt_o(gnt), .hwpe_add_i(add), .hwpe_wen_i(wen),
    .hwpe_be_i(be), .hwpe_data_i(wdata), .hwpe_r_data_o(rdata), .hwpe_r_valid_o(rvalid),
    .tcdm_q_valid_o(qv), .tcdm_q_ready_i(qr), .tcdm_q_addr_o(qaddr), .tcdm_q_write_o(qw),
    .tcdm_q_data_o(qd), .tcdm_q_strb_o(qs), .tcdm_p_valid_i(pv), .tcdm_p_data_i(pd),
    .tcdm_p_ready_o(pr), .busy_o(busy), .err_o(err));
  snax_hwpe_to_reqrsp_wide #(.DataWidth(128), .AddrShift(1)) u_wide (
    .clk_i(clk), .rst_i(rst), .hwpe_req_i(w_req), .hwpe_gnt_o(w_gnt), .hwpe_add_i(w_add), .hwpe_wen_i(w_wen),
    .hwpe_be_i(w_be), .hwpe_data_i(w_wdata), .hwpe_r_data_o(w_rdata), .hwpe_r_valid_o(w_rvalid),
    .tcdm_q_valid_o(w_qv), .tcdm_q_ready_i(w_qr), .tcdm_q_addr_o(w_qaddr), .tcdm_q_write_o(w_qw),
    .tcdm_q_data_o(w_qd), .tcdm_q_strb_o(w_qs), .tcdm_p_valid_i(w_pv), .tcdm_p_data_i(w_pd),
    .tcdm_p_ready_o(w_pr), .busy_o(w_busy), .err_o(w_err));
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  typedef struct {logic wen; logic [31:0] addr; logic [3:0] be; logic [31:0] data; logic [63:0] pdata; logic [7:0] strb; logic rv; logic [31:0] rd;} vec_t;
  vec_t vt[6];
  typedef struct {logic [47:0] addr; logic wr; logic [63:0] data; logic [7:0] strb; int lane;} ent_t;
  ent_t reqq[$], iss[$], e;
  int out, n;
  logic eg, erv, drain;
  task automatic txn(input vec_t v);
    @(negedge clk); req = 1; add = v.addr; wen = v.wen; be = v.be; wdata = v.data; qr = 1; pv = 0;
    #1 chk("txn_gnt", gnt, 1);
    @(negedge clk); req = 0;
    #1 chk("txn_qvalid", qv, 1);
    chk("txn_qaddr", qaddr, {16'h0, v.addr});
    chk("txn_qwrite", qw, !v.wen);
    chk("txn_qstrb", qs, v.strb);
    if (!v.wen) chk("txn_qdata", qd, {v.data, v.data});
    @(negedge clk); pv = 1; pd = v.pdata;
    #1 chk("txn_rvalid", rvalid, v.rv);
    chk("txn_rdata", rdata, v.rd);
    chk("txn_qdrained", qv, 0);
    @(negedge clk); pv = 0;
    #1 chk("txn_rvalid_off", rvalid, 0);
    chk("txn_busy", busy, 0);
  endtask
  initial begin
    vt[0] = '{1'b1, 32'h1000_0004, 4'hF, 32'h0, 64'h1234_ABCD_DEAD_BEEF, 8'hFF, 1'b1, 32'h1234_ABCD};
    vt[1] = '{1'b1, 32'h0000_0024, 4'hF, 32'h0, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b1, 32'hAAAA_BBBB};
    vt[2] = '{1'b0, 32'h0000_0020, 4'h3, 32'h0000_55AA, 64'hAAAA_BBBB_CCCC_DDDD, 8'h03, 1'b0, 32'h0};
    vt[3] = '{1'b1, 32'h0000_0020, 4'hF, 32'h0, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b1, 32'hCCCC_DDDD};
    vt[4] = '{1'b0, 32'h0000_0004, 4'hC, 32'h1357_9BDF, 64'h0, 8'hC0, 1'b0, 32'h0};
    vt[5] = '{1'b0, 32'h0000_000C, 4'hF, 32'hFEED_F00D, 64'h0, 8'hF0, 1'b0, 32'h0};
    req = 1; w_req = 1; pv = 1;
    @(negedge clk);
    #1 chk("rst_gnt", gnt, 0);
    chk("rst_qvalid", qv, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_gnt", w_gnt, 0);
    @(negedge clk); req = 0; w_req = 0; pv = 0;
    #1 chk("rst_err", err, 0);
    rst = 0;
    for (int i = 0; i < 6; i++) txn(vt[i]);
    @(negedge clk); w_req = 1; w_add = 32'h8; w_wen = 0; w_be = 4'b0011; w_wdata = 32'hC0DE_BABE;
    #1 chk("wide_gnt", w_gnt, 1);
    @(negedge clk); w_req = 0;
    #1 chk("wide_qaddr", w_qaddr, 48'h10);
    chk("wide_qstrb", w_qs, 16'h0003);
    chk("wide_qdata", w_qd, {4{32'hC0DE_BABE}});
    chk("wide_qwrite", w_qw, 1);
    @(negedge clk); w_pv = 1;
    #1 chk("wide_wr_rvalid", w_rvalid, 0);
    @(negedge clk); w_pv = 0; w_req = 1; w_add = 32'h6; w_wen = 1;
    #1 chk("wide_rd_gnt", w_gnt, 1);
    @(negedge clk); w_req = 0;
    #1 chk("wide_rd_qaddr", w_qaddr, 48'hC);
    chk("wide_rd_qstrb", w_qs, 16'hFFFF);
    @(negedge clk); w_pv = 1; w_pd = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    #1 chk("wide_rvalid", w_rvalid, 1);
    chk("wide_rdata", w_rdata, 32'h4444_4444);
    @(negedge clk); w_pv = 0;
    #1 chk("wide_busy", w_busy, 0);
    for (int c = 0; c < 1600; c++) begin
      @(negedge clk);
      drain = c >= 1500;
      req = !drain && $urandom_range(0, 2) != 0;
      add = $urandom; wen = 1'($urandom_range(0, 1)); be = 4'($urandom); wdata = $urandom;
      qr = drain || $urandom_range(0, 3) != 0;
      pv = iss.size() > 0 && (drain || $urandom_range(0, 2) != 0);
      pd = {$urandom, $urandom};
      #1;
      out = reqq.size() + iss.size();
      eg = req && reqq.size() < 8 && out < 8;
      chk("rnd_gnt", gnt, eg);
      chk("rnd_qvalid", qv, reqq.size() > 0);
      if (reqq.size() > 0) begin
        chk("rnd_qaddr", qaddr, reqq[0].addr);
        chk("rnd_qwrite", qw, reqq[0].wr);
        chk("rnd_qstrb", qs, reqq[0].strb);
        if (reqq[0].wr) chk("rnd_qdata", qd, reqq[0].data);
      end
      erv = pv && !iss[0].wr;
      chk("rnd_rvalid", rvalid, erv);
      chk("rnd_rdata", rdata, erv ? 32'(pd >> (32 * iss[0].lane)) : 32'h0);
      chk("rnd_busy", busy, out > 0);
      chk("rnd_err", err, 0);
      if (pv) void'(iss.pop_front());
      if (reqq.size() > 0 && qr) iss.push_back(reqq.pop_front());
      if (eg) begin
        e.lane = int'((add >> 2) & 32'h1);
        e.wr = !wen;
        e.addr = 48'(add);
        e.data = {wdata, wdata};
        e.strb = e.wr ? 8'(8'(be) << (4 * e.lane)) : 8'hFF;
        reqq.push_back(e);
      end
    end
    @(negedge clk); req = 0; pv = 0; qr = 0; wen = 1; be = 4'hF; n = 0; req = 1;
    for (int i = 0; i < 12; i++) begin
      add = 32'h100 + 32'(4 * n);
      #1 if (gnt) n++;
      @(negedge clk);
    end
    #1 chk("bp_accepts", n, 8);
    chk("bp_gnt_low", gnt, 0);
    req = 0; qr = 1;
    for (int i = 0; i < 8; i++) begin
      #1 chk("bp_qvalid", qv, 1);
      chk("bp_qaddr", qaddr, 48'h100 + 48'(4 * i));
      chk("bp_qstrb", qs, 8'hFF);
      @(negedge clk);
    end
    #1 chk("bp_empty", qv, 0);
    for (int i = 0; i < 8; i++) begin
      pv = 1; pd = {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
      #1 chk("bp_rvalid", rvalid, 1);
      chk("bp_rdata", rdata, (i % 2) ? 32'hB000_0000 + 32'(i) : 32'hA000_0000 + 32'(i));
      @(negedge clk);
    end
    pv = 0;
    #1 chk("bp_busy", busy, 0);
    n = 0; req = 1;
    for (int i = 0; i < 12; i++) begin
      add = 32'h200 + 32'(4 * n);
      #1 if (gnt) n++;
      @(negedge clk);
    end
    #1 chk("cr_accepts", n, 8);
    chk("cr_gnt_low", gnt, 0);
    chk("cr_qempty", qv, 0);
    pv = 1;
    #1 chk("cr_full_gnt", gnt, 0);
    chk("cr_rvalid", rvalid, 1);
    @(negedge clk); pv = 0;
    #1 chk("cr_one_more", gnt, 1);
    @(negedge clk);
    #1 chk("cr_full_again", gnt, 0);
    pv = 1;
    @(negedge clk);
    #1 chk("cr_both_gnt", gnt, 1);
    chk("cr_both_rvalid", rvalid, 1);
    @(negedge clk); pv = 0;
    #1 chk("cr_held_gnt", gnt, 1);
    chk("cr_busy", busy, 1);
    @(negedge clk);
    #1 chk("cr_capped", gnt, 0);
    req = 0;
    for (int i = 0; i < 8; i++) begin
      pv = 1;
      #1 chk("cr_drain_rvalid", rvalid, 1);
      @(negedge clk);
    end
    pv = 0;
    #1 chk("cr_idle", busy, 0);
    chk("cr_no_err", err, 0);
    @(negedge clk); pv = 1;
    #1 chk("err_rvalid", rvalid, 0);
    @(negedge clk); pv = 0;
    #1 chk("err_set", err, 1);
    @(negedge clk);
    #1 chk("err_sticky", err, 1);
    qr = 0; req = 1; wen = 1;
    for (int i = 0; i < 3; i++) begin
      add = 32'h300 + 32'(4 * i);
      @(negedge clk);
    end
    req = 0;
    #1 chk("pre_rst_busy", busy, 1);
    @(negedge clk); rst = 1; req = 1; pv = 1;
    #1 chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_qvalid", qv, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk); rst = 0; req = 0; pv = 1;
    #1 chk("post_rst_err", err, 0);
    chk("post_rst_rvalid", rvalid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_qvalid", qv, 0);
    @(negedge clk); pv = 0; qr = 1;
    #1 chk("post_rst_err2", err, 0);
    txn(vt[0]);
    chk("final_err", err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
